// File: rtl/sbox_lane_pipe_if.sv
// Stream bundle for the AES byte-substitution lane pipeline.
// master = upstream/downstream driver side, slave = the substitution block.
interface sbox_lane_pipe_if #(
    parameter int LANES = 4
);
    logic                 i_Valid;
    logic                 o_Ready;
    logic                 i_Inv;
    logic [8*LANES-1:0]   i_Din;
    logic                 o_Valid;
    logic                 i_Ready;
    logic [8*LANES-1:0]   o_Dout;
    logic                 o_Busy;

    modport master (
        output i_Valid, i_Inv, i_Din, i_Ready,
        input  o_Ready, o_Valid, o_Dout, o_Busy
    );

    modport slave (
        input  i_Valid, i_Inv, i_Din, i_Ready,
        output o_Ready, o_Valid, o_Dout, o_Busy
    );
endinterface

// File: rtl/sbox_lane_pipe.sv
// Elastic 1- or 2-stage pipeline applying the AES forward or inverse S-box to
// LANES bytes per beat; the mode bit travels with each beat.
module sbox_lane_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input logic             i_Clk,
    input logic             i_Rst,
    sbox_lane_pipe_if.slave bus
);
    localparam int W = 8 * LANES;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = inv ? sbox_inv(d[8*k +: 8]) : sbox_fwd(d[8*k +: 8]);
        return r;
    endfunction

    logic [W-1:0] dout_p2;
    logic         vld_p2;
    logic         load_p2;
    logic         load_p1;
    logic [W-1:0] sub_din;
    logic         sub_inv;
    logic         sub_vld;
    logic         busy_p1;

    assign load_p2 = !vld_p2 || bus.i_Ready;

    generate
        if (PIPE_STAGES == 2) begin : g_two
            logic [W-1:0] din_p1;
            logic         inv_p1;
            logic         vld_p1;

            // stage 1: capture raw bytes and mode
            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    vld_p1 <= 1'b0;
                    din_p1 <= '0;
                    inv_p1 <= 1'b0;
                end else if (load_p1) begin
                    vld_p1 <= bus.i_Valid;
                    if (bus.i_Valid) begin
                        din_p1 <= bus.i_Din;
                        inv_p1 <= bus.i_Inv;
                    end
                end
            end

            assign load_p1 = !vld_p1 || load_p2;
            assign sub_din = din_p1;
            assign sub_inv = inv_p1;
            assign sub_vld = vld_p1;
            assign busy_p1 = vld_p1;
        end else begin : g_one
            assign load_p1 = load_p2;
            assign sub_din = bus.i_Din;
            assign sub_inv = bus.i_Inv;
            assign sub_vld = bus.i_Valid;
            assign busy_p1 = 1'b0;
        end
    endgenerate

    // output stage: lookup result; data only moves on a real beat so bubbles hold it
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            vld_p2  <= 1'b0;
            dout_p2 <= '0;
        end else if (load_p2) begin
            vld_p2 <= sub_vld;
            if (sub_vld) dout_p2 <= sub_word(sub_din, sub_inv);
        end
    end

    assign bus.o_Ready = load_p1;
    assign bus.o_Valid = vld_p2;
    assign bus.o_Dout  = dout_p2;
    assign bus.o_Busy  = vld_p2 || busy_p1;
endmodule

// File: doc/sbox_lane_pipe.md
Name: sbox_lane_pipe

Overview:
Parametrised, pipelined AES byte-substitution engine. It applies either the forward S-box (encryption SubBytes) or the inverse S-box (decryption InvSubBytes) to LANES bytes in parallel. Mode is selectable per beat, and a valid/ready handshake with full backpressure carries data through. It sits between the round-state register and ShiftRows/InvShiftRows in the AES encrypt/decrypt datapath, and replaces the fixed single-byte combinational lookup tables.

Parameters:
LANES, 4, number of byte lanes processed per beat (1..16; 16 = full AES state)
PIPE_STAGES, 2, register stages from input to output (1 or 2 only)

Ports:
i_Clk  input  1  clock; all state changes on rising edge
i_Rst  input  1  synchronous reset, active-high
i_Valid  input  1  input beat valid
o_Ready  output  1  block can accept a beat this cycle
i_Inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat
i_Din  input  8*LANES  input bytes; lane k occupies bits [8k+7:8k]
o_Valid  output  1  output beat valid
i_Ready  input  1  downstream accepts output beat
o_Dout  output  8*LANES  substituted bytes; same lane mapping as i_Din
o_Busy  output  1  high while any pipeline stage holds a valid beat

Behaviour:
- Reset (i_Rst=1 at clock edge): all stage valid flags cleared; all data registers cleared to 0.
- Outputs directly after reset: o_Valid=0, o_Dout=0, o_Busy=0, o_Ready=1.
- Reset mid-operation: in-flight beats are discarded, not flushed. Reset takes priority over every other event in the same cycle.
- Input transfer: occurs when i_Valid & o_Ready at a clock edge.
- Output transfer: occurs when o_Valid & i_Ready at a clock edge.
- Lookup per lane: forward S-box when i_Inv=0, inverse S-box when i_Inv=1 (FIPS-197 tables).
- Every lane of a beat uses that beat's i_Inv; there is no per-lane mode.
- i_Inv travels with the beat through the pipeline. Mode changes between consecutive beats take effect with no bubble.
- PIPE_STAGES=1:
  - Lookup is combinational on i_Din and captured in the output register.
  - Latency is 1: a beat accepted at edge N is on o_Dout with o_Valid=1 after edge N.
- PIPE_STAGES=2:
  - Stage 1 registers {i_Din, i_Inv}; lookup runs on the stage-1 register; stage 2 (the output register) captures the result.
  - Latency is 2.
- Stage advance rule (elastic pipeline): stage s loads when it is empty or its contents move on this cycle.
  - Last stage moves on when i_Ready=1.
  - Stage s moves on when stage s+1 loads.
- o_Ready = stage-1 empty OR stage-1 advancing.
  - Combinational from i_Ready. This is a documented combinational path; downstream must not make i_Ready depend on o_Ready.
- Throughput: one beat per cycle while i_Ready=1.
- Backpressure (i_Ready=0): o_Valid and o_Dout hold stable until accepted. The pipeline fills and then o_Ready drops. No beat is dropped or duplicated.
- Simultaneous input and output transfer on a full pipeline: allowed. The pipe shifts and stays full.
- Bubbles: when o_Valid=0, o_Dout holds its last value. It is not cleared and not forced to X.
- o_Busy = OR of all stage valid flags.
- Ordering: beats exit strictly in acceptance order.
- Table implementation is free (case ROM or GF(2^8) inversion plus affine), provided the result is bit-exact to FIPS-197 and the stated latency holds.

Test Plan:
1. LANES=4, PIPE_STAGES=2, i_Ready=1. One beat i_Din=32'h00_53_63_ED, i_Inv=0 -> exactly 2 cycles later o_Valid=1, o_Dout=32'h63_ED_FB_55 for one cycle.
2. Same data, i_Inv=1 -> o_Dout=32'h52_50_00_53. Back-to-back beats alternating i_Inv=0/1 -> outputs alternate 32'h63_ED_FB_55 / 32'h52_50_00_53 at one per cycle, with no bubbles.
3. Exhaustive check: stream bytes 0x00..0xFF across all lanes in both modes, then feed the forward output back with i_Inv=1 -> every recovered byte equals the original; output matches the FIPS-197 tables.
4. Backpressure: stream 8 beats while holding i_Ready=0 for cycles 3..7 -> o_Ready deasserts once 2 beats are buffered; o_Dout stays stable while stalled; all 8 results arrive in order with no loss or duplication.
5. Reset mid-stream: assert i_Rst for 1 cycle while 2 beats are in flight -> next cycle o_Valid=0, o_Busy=0, o_Dout=0, o_Ready=1; neither dropped beat ever appears.
6. PIPE_STAGES=1, LANES=16: accepted beat appears after 1 cycle. With i_Din all bytes 0x01 and i_Inv=0 -> o_Dout all bytes 0x7C; with i_Inv=1 -> all bytes 0x09.
